// File: rtl/sum_uart_reporter.sv
// Captures two operands from data_input on save strobes, adds them, and reports
// the sum as uppercase ASCII hex plus CR LF over an 8N1 UART. Define
// SUM_ECHO_OPERANDS_EN to send "A+B=SUM" CR LF instead of the sum alone.
module sum_uart_reporter #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  output logic              uart_txd,
  output logic              uart_tx_busy,
  output logic [DATA_W:0]   sum,
  output logic              frame_done
);

  localparam int NDIG = (DATA_W + 4) / 4;
  localparam int NOPD = (DATA_W + 3) / 4;
`ifdef SUM_ECHO_OPERANDS_EN
  localparam int SUM_OFS = 2 * NOPD + 2;
`else
  localparam int SUM_OFS = 0;
`endif
  localparam int NBYTES = SUM_OFS + NDIG + 2;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, SHIFT, DONE} state_t;

  logic [1:0]        aSync_q, bSync_q;
  logic              aPrev_q, bPrev_q;
  logic [DATA_W-1:0] dataSync1_q, dataSync2_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W:0]   sum_q, sum_d;
  logic              capA, capB, trigger;

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic [4:0]        byteIdx_q, byteIdx_d;
  logic [3:0]        bitCnt_q, bitCnt_d;
  logic [BAUD_W-1:0] baudCnt_q, baudCnt_d;
  logic [9:0]        shift_q, shift_d;
  logic [DATA_W:0]   frameSum_q, frameSum_d;
  logic [7:0]        curByte;
  logic [4*NDIG-1:0] sumPad;
`ifdef SUM_ECHO_OPERANDS_EN
  logic [DATA_W-1:0] frameA_q, frameA_d, frameB_q, frameB_d;
  logic [4*NOPD-1:0] opAPad, opBPad;
`endif

  function automatic logic [7:0] hexChar(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Strobe synchronisers idle high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      aSync_q     <= 2'b11;
      bSync_q     <= 2'b11;
      aPrev_q     <= 1'b1;
      bPrev_q     <= 1'b1;
      dataSync1_q <= '0;
      dataSync2_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
    end else begin
      aSync_q     <= {aSync_q[0], save_a_n};
      bSync_q     <= {bSync_q[0], save_b_n};
      aPrev_q     <= aSync_q[1];
      bPrev_q     <= bSync_q[1];
      dataSync1_q <= data_input;
      dataSync2_q <= dataSync1_q;
      if (capA) a_q <= dataSync2_q;
      if (capB) b_q <= dataSync2_q;
      sum_q       <= sum_d;
    end
  end

  assign capA    = aPrev_q & ~aSync_q[1];
  assign capB    = bPrev_q & ~bSync_q[1];
  assign trigger = capA | capB;
  assign sum_d   = {1'b0, a_q} + {1'b0, b_q};
  assign sum     = sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      byteIdx_q  <= '0;
      bitCnt_q   <= '0;
      baudCnt_q  <= '0;
      shift_q    <= '1;
      frameSum_q <= '0;
`ifdef SUM_ECHO_OPERANDS_EN
      frameA_q   <= '0;
      frameB_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      byteIdx_q  <= byteIdx_d;
      bitCnt_q   <= bitCnt_d;
      baudCnt_q  <= baudCnt_d;
      shift_q    <= shift_d;
      frameSum_q <= frameSum_d;
`ifdef SUM_ECHO_OPERANDS_EN
      frameA_q   <= frameA_d;
      frameB_q   <= frameB_d;
`endif
    end
  end

  // Character at the current byte index; anything past CR is the trailing LF.
  always_comb begin
    curByte = 8'h0A;
    sumPad  = '0;
    sumPad[DATA_W:0] = frameSum_q;
`ifdef SUM_ECHO_OPERANDS_EN
    opAPad = '0;
    opBPad = '0;
    opAPad[DATA_W-1:0] = frameA_q;
    opBPad[DATA_W-1:0] = frameB_q;
    for (int i = 0; i < NOPD; i++) begin
      if (byteIdx_q == 5'(i)) curByte = hexChar(opAPad[4*(NOPD-1-i) +: 4]);
      if (byteIdx_q == 5'(NOPD + 1 + i)) curByte = hexChar(opBPad[4*(NOPD-1-i) +: 4]);
    end
    if (byteIdx_q == 5'(NOPD)) curByte = 8'h2B;
    if (byteIdx_q == 5'(2 * NOPD + 1)) curByte = 8'h3D;
`endif
    for (int i = 0; i < NDIG; i++) begin
      if (byteIdx_q == 5'(SUM_OFS + i)) curByte = hexChar(sumPad[4*(NDIG-1-i) +: 4]);
    end
    if (byteIdx_q == 5'(SUM_OFS + NDIG)) curByte = 8'h0D;
  end

  // LOAD snapshots a_q + b_q directly, since sum_q lags the operands by a cycle.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    byteIdx_d    = byteIdx_q;
    bitCnt_d     = bitCnt_q;
    baudCnt_d    = baudCnt_q;
    shift_d      = shift_q;
    frameSum_d   = frameSum_q;
`ifdef SUM_ECHO_OPERANDS_EN
    frameA_d     = frameA_q;
    frameB_d     = frameB_q;
`endif
    frame_done   = 1'b0;
    uart_tx_busy = 1'b1;
    case (state_q)
      IDLE: begin
        uart_tx_busy = 1'b0;
        if (trigger) state_d = LOAD;
      end
      LOAD: begin
        if (trigger) pending_d = 1'b1;
        frameSum_d = sum_d;
`ifdef SUM_ECHO_OPERANDS_EN
        frameA_d   = a_q;
        frameB_d   = b_q;
`endif
        byteIdx_d  = '0;
        state_d    = START;
      end
      START: begin
        if (trigger) pending_d = 1'b1;
        shift_d   = {1'b1, curByte, 1'b0};
        bitCnt_d  = '0;
        baudCnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (trigger) pending_d = 1'b1;
        if (baudCnt_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
          baudCnt_d = '0;
          if (bitCnt_q == 4'd9) begin
            if (byteIdx_q == 5'(NBYTES - 1)) begin
              state_d = DONE;
            end else begin
              byteIdx_d = byteIdx_q + 5'd1;
              state_d   = START;
            end
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
            shift_d  = {1'b1, shift_q[9:1]};
          end
        end else begin
          baudCnt_d = baudCnt_q + BAUD_W'(1);
        end
      end
      DONE: begin
        frame_done = 1'b1;
        if (pending_q || trigger) begin
          pending_d = 1'b0;
          state_d   = LOAD;
        end else begin
          uart_tx_busy = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign uart_txd = (state_q == SHIFT) ? shift_q[0] : 1'b1;

endmodule

// File: tb/tb_sum_uart_reporter.sv
// Bench for sum_uart_reporter: a 4-bit and an 8-bit instance, checked cycle by
// cycle against frames built from the operand values with plain arithmetic.
module tb_sum_uart_reporter;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sa4 = 1'b1, sb4 = 1'b1, sa8 = 1'b1, sb8 = 1'b1;
  logic [3:0] d4 = '0;
  logic [7:0] d8 = '0;
  logic       txd4, busy4, fd4, txd8, busy8, fd8;
  logic [4:0] sum4;
  logic [8:0] sum8;

  int nCompared = 0;
  int nMismatched = 0;
  int mA[2];
  int mB[2];
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  sum_uart_reporter #(.DATA_W(4), .CLKS_PER_BIT(CPB)) u4 (
    .clk(clk), .reset(reset), .save_a_n(sa4), .save_b_n(sb4), .data_input(d4),
    .uart_txd(txd4), .uart_tx_busy(busy4), .sum(sum4), .frame_done(fd4)
  );

  sum_uart_reporter #(.DATA_W(8), .CLKS_PER_BIT(CPB)) u8 (
    .clk(clk), .reset(reset), .save_a_n(sa8), .save_b_n(sb8), .data_input(d8),
    .uart_txd(txd8), .uart_tx_busy(busy8), .sum(sum8), .frame_done(fd8)
  );

  function automatic logic txdOf(input bit w);  return w ? txd8 : txd4;   endfunction
  function automatic logic busyOf(input bit w); return w ? busy8 : busy4; endfunction
  function automatic logic fdOf(input bit w);   return w ? fd8 : fd4;     endfunction
  function automatic int   sumOf(input bit w);  return w ? int'(sum8) : int'(sum4); endfunction

  function automatic logic [7:0] hexAscii(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // Reference frame: fixed-width uppercase hex, optional operand echo, then CR LF.
  function automatic void buildFrame(input int w, input int a, input int b);
    int s, nd, no;
    s  = a + b;
    nd = (w + 4) / 4;
    no = (w + 3) / 4;
    expQ.delete();
`ifdef SUM_ECHO_OPERANDS_EN
    for (int i = 0; i < no; i++) expQ.push_back(hexAscii((a >> (4 * (no - 1 - i))) & 15));
    expQ.push_back(8'h2B);
    for (int i = 0; i < no; i++) expQ.push_back(hexAscii((b >> (4 * (no - 1 - i))) & 15));
    expQ.push_back(8'h3D);
`endif
    for (int i = 0; i < nd; i++) expQ.push_back(hexAscii((s >> (4 * (nd - 1 - i))) & 15));
    expQ.push_back(8'h0D);
    expQ.push_back(8'h0A);
  endfunction

  // Pulls a strobe low with new data and returns just after the capture edge.
  task automatic strobe(input bit which, input bit isB, input int value);
    @(posedge clk); #1;
    if (which) begin
      d8 = 8'(value);
      if (isB) sb8 = 1'b0; else sa8 = 1'b0;
    end else begin
      d4 = 4'(value);
      if (isB) sb4 = 1'b0; else sa4 = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    sa4 = 1'b1; sb4 = 1'b1; sa8 = 1'b1; sb8 = 1'b1;
    if (isB) mB[which] = value; else mA[which] = value;
  endtask

  // Follows a frame from its LOAD cycle through DONE, checking every cycle.
  task automatic checkFrame(input bit which, input bit expPending);
    int timingErr;
    logic [9:0] expBits, got;
    timingErr = 0;
    @(negedge clk);
    if (txdOf(which) !== 1'b1 || busyOf(which) !== 1'b1 || fdOf(which) !== 1'b0) timingErr++;
    for (int k = 0; k < expQ.size(); k++) begin
      expBits = {1'b1, expQ[k], 1'b0};
      got = '0;
      @(negedge clk);
      if (txdOf(which) !== 1'b1 || busyOf(which) !== 1'b1 || fdOf(which) !== 1'b0) timingErr++;
      for (int n = 0; n < 10; n++) begin
        for (int c = 0; c < CPB; c++) begin
          @(negedge clk);
          if (c == CPB / 2) got[n] = txdOf(which);
          if (txdOf(which) !== expBits[n] || busyOf(which) !== 1'b1 || fdOf(which) !== 1'b0)
            timingErr++;
        end
      end
      nCompared++;
      if (got !== expBits) begin
        nMismatched++;
        $display("[TB] FAIL frame_byte[%0d]: got bits %b, expected %b", k, got, expBits);
      end
    end
    nCompared++;
    if (timingErr != 0) begin
      nMismatched++;
      $display("[TB] FAIL bit_timing: got %0d bad cycles, expected 0", timingErr);
    end
    @(negedge clk);
    nCompared++;
    if ({fdOf(which), busyOf(which), txdOf(which)} !== {1'b1, expPending, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL done_cycle: got fd/busy/txd %b%b%b, expected 1%b1",
               fdOf(which), busyOf(which), txdOf(which), expPending);
    end
    if (!expPending) begin
      @(negedge clk);
      nCompared++;
      if ({fdOf(which), busyOf(which), txdOf(which)} !== 3'b001) begin
        nMismatched++;
        $display("[TB] FAIL idle_after_frame: got fd/busy/txd %b%b%b, expected 001",
                 fdOf(which), busyOf(which), txdOf(which));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nCompared++;
    if ({txd4, busy4, fd4, sum4} !== {1'b1, 1'b0, 1'b0, 5'h00}) begin
      nMismatched++;
      $display("[TB] FAIL reset_state4: got txd/busy/fd/sum %b/%b/%b/%h, expected 1/0/0/00",
               txd4, busy4, fd4, sum4);
    end
    nCompared++;
    if ({txd8, busy8, fd8, sum8} !== {1'b1, 1'b0, 1'b0, 9'h000}) begin
      nMismatched++;
      $display("[TB] FAIL reset_state8: got txd/busy/fd/sum %b/%b/%b/%h, expected 1/0/0/000",
               txd8, busy8, fd8, sum8);
    end
    reset = 1'b0;
    mA = '{0, 0};
    mB = '{0, 0};
  endtask

  task automatic checkSum(input bit which);
    nCompared++;
    if (sumOf(which) !== mA[which] + mB[which]) begin
      nMismatched++;
      $display("[TB] FAIL sum%0d: got %0h, expected %0h", which, sumOf(which), mA[which] + mB[which]);
    end
  endtask

  task automatic test_basic();
    strobe(0, 0, 9);
    buildFrame(4, mA[0], mB[0]);
    checkFrame(0, 0);
    strobe(0, 1, 8);
    buildFrame(4, mA[0], mB[0]);
    checkFrame(0, 0);
    checkSum(0);
  endtask

  task automatic test_max_operands();
    strobe(0, 0, 15);
    buildFrame(4, mA[0], mB[0]);
    checkFrame(0, 0);
    strobe(0, 1, 15);
    buildFrame(4, mA[0], mB[0]);
    checkFrame(0, 0);
    checkSum(0);
  endtask

  task automatic test_coalesce();
    strobe(0, 1, int'($urandom_range(0, 15)));
    buildFrame(4, mA[0], mB[0]);
    fork
      checkFrame(0, 1);
      begin
        repeat (10) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          strobe(0, 1, int'($urandom_range(0, 15)));
          repeat (5) @(posedge clk);
        end
      end
    join
    buildFrame(4, mA[0], mB[0]);
    checkFrame(0, 0);
    checkSum(0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      strobe(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      buildFrame(4, mA[0], mB[0]);
      checkFrame(0, 0);
      checkSum(0);
    end
    for (int i = 0; i < 2; i++) begin
      strobe(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      buildFrame(8, mA[1], mB[1]);
      checkFrame(1, 0);
      checkSum(1);
    end
  endtask

  task automatic test_wide();
    strobe(1, 0, 8'hFF);
    buildFrame(8, mA[1], mB[1]);
    checkFrame(1, 0);
    strobe(1, 1, 8'h01);
    buildFrame(8, mA[1], mB[1]);
    checkFrame(1, 0);
    checkSum(1);
  endtask

  // Reset lands in the middle of data bit 1 of the second byte.
  task automatic test_reset_midframe();
    int noisy;
    strobe(0, 0, int'($urandom_range(1, 15)));
    buildFrame(4, mA[0], mB[0]);
    repeat (53) @(negedge clk);
    nCompared++;
    if (txd4 !== expQ[1][1]) begin
      nMismatched++;
      $display("[TB] FAIL pre_reset_bit: got %b, expected %b", txd4, expQ[1][1]);
    end
    reset = 1'b1;
    @(negedge clk);
    nCompared++;
    if ({txd4, busy4, sum4} !== {1'b1, 1'b0, 5'h00}) begin
      nMismatched++;
      $display("[TB] FAIL midframe_reset: got txd/busy/sum %b/%b/%h, expected 1/0/00", txd4, busy4, sum4);
    end
    reset = 1'b0;
    mA = '{0, 0};
    mB = '{0, 0};
    noisy = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd4 !== 1'b1 || busy4 !== 1'b0 || fd4 !== 1'b0) noisy++;
    end
    nCompared++;
    if (noisy != 0) begin
      nMismatched++;
      $display("[TB] FAIL quiet_after_reset: got %0d active cycles, expected 0", noisy);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_coalesce();
    test_random();
    test_wide();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
